// File: rtl/uart_rx_if.sv
// Serial input and received-byte outputs of the UART receiver.
// slave: the receiver side; master: the line driver / byte consumer side.
interface uart_rx_if;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    modport slave (
        input  rx_serial,
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_busy
    );

    modport master (
        output rx_serial,
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Samples each bit at its mid-point, using the start-bit
// half period to align, and returns to idle at mid-stop-bit. This leaves half
// a bit time to catch a start bit that immediately follows the stop bit.
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic     clk,
    input  logic     rst_,
    uart_rx_if.slave bus
);

    localparam int unsigned DIVISOR = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF    = DIVISOR / 2;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e      state_q, state_d;
    logic [31:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_index_q, bit_index_d;
    logic [7:0]  shifter_q, shifter_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        frame_err_q, frame_err_d;
    logic        busy_q, busy_d;
    logic        sync1_q, sync2_q;
    logic        rx_sync;

    assign rx_sync = sync2_q;

    // Two-flop synchroniser for the asynchronous serial line; resets to idle-high.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.rx_serial;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic: mid-bit sampling, shifting and the one-cycle result pulses.
    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_index_d = bit_index_q;
        shifter_d   = shifter_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                baud_cnt_d = '0;
                if (!rx_sync) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                baud_cnt_d = baud_cnt_q + 32'd1;
                if (baud_cnt_q == HALF - 1) begin
                    baud_cnt_d = '0;
                    if (!rx_sync) begin
                        state_d     = StData;
                        bit_index_d = '0;
                    end else begin
                        // Line went back high before mid start bit: a glitch.
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                baud_cnt_d = baud_cnt_q + 32'd1;
                if (baud_cnt_q == DIVISOR - 1) begin
                    baud_cnt_d = '0;
                    shifter_d  = {rx_sync, shifter_q[7:1]};
                    if (bit_index_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_index_d = bit_index_q + 3'd1;
                    end
                end
            end
            StStop: begin
                baud_cnt_d = baud_cnt_q + 32'd1;
                if (baud_cnt_q == DIVISOR - 1) begin
                    baud_cnt_d = '0;
                    state_d    = StIdle;
                    if (rx_sync) begin
                        data_d  = shifter_q;
                        valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = StIdle;
                baud_cnt_d = '0;
            end
        endcase
        // Busy is registered alongside the state so it drops with the pulse.
        busy_d = (state_d != StIdle);
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= StIdle;
            baud_cnt_q  <= '0;
            bit_index_q <= '0;
            shifter_q   <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_index_q <= bit_index_d;
            shifter_q   <= shifter_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.rx_data      = data_q;
    assign bus.rx_valid     = valid_q;
    assign bus.rx_frame_err = frame_err_q;
    assign bus.rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a behavioural 8N1 transmitter drives the line,
// pushes the expected outcome of each frame, and a monitor checks every pulse.
module tb_uart_rx;

    localparam int unsigned CLK_FREQ  = 160;
    localparam int unsigned BAUD_RATE = 10;
    localparam int DIV     = CLK_FREQ / BAUD_RATE;
    localparam int HALF    = DIV / 2;
    localparam int LATENCY = 2 + 1 + HALF + 9 * DIV;
    localparam int TOL     = 2;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk;
    logic rst_;
    int   cyc;
    int   total;
    int   bad;
    exp_t exp_q[$];
    logic [7:0] last_good;

    uart_rx_if u_if ();

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_ && (u_if.rx_valid || u_if.rx_frame_err)) begin
            check("valid_and_err_exclusive", {31'd0, u_if.rx_valid & u_if.rx_frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind_err", {31'd0, u_if.rx_frame_err}, {31'd0, e.err});
                check("rx_data", {24'd0, u_if.rx_data}, {24'd0, e.data});
                check_range("pulse_timing", cyc, e.due - TOL, e.due + TOL);
            end
        end
    end

    // Hold one bit for exactly one bit period; caller sits at posedge + 1.
    task automatic hold_bit(input bit v);
        u_if.rx_serial = v;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        u_if.rx_serial = 1'b1;
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Reference behaviour: good stop -> byte delivered; low stop -> error, data kept.
    task automatic send_frame(input logic [7:0] b, input bit stop);
        exp_t e;
        e.err  = !stop;
        e.data = stop ? b : last_good;
        e.due  = cyc + LATENCY;
        exp_q.push_back(e);
        if (stop) last_good = b;
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stop);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check(name, exp_q.size(), 32'd0);
        exp_q.delete();
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;
        logic [7:0] b;
        bit stop;
        int gap;

        total = 0;
        bad = 0;
        cyc = 0;
        last_good = 8'h00;
        u_if.rx_serial = 1'b1;
        rst_ = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data", {24'd0, u_if.rx_data}, 32'd0);
        check("reset_rx_valid", {31'd0, u_if.rx_valid}, 32'd0);
        check("reset_rx_frame_err", {31'd0, u_if.rx_frame_err}, 32'd0);
        check("reset_rx_busy", {31'd0, u_if.rx_busy}, 32'd0);
        rst_ = 1'b1;
        @(posedge clk);
        #1;
        idle(10);

        // Single frame with busy sampled before and after synchroniser delay.
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(negedge clk);
                check("busy_before_sync", {31'd0, u_if.rx_busy}, 32'd0);
                repeat (5) @(negedge clk);
                check("busy_in_frame", {31'd0, u_if.rx_busy}, 32'd1);
            end
        join
        idle(20);

        // Back-to-back frames without an idle gap.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        drain("drain_back_to_back");

        // Short low glitch: brief busy, no pulse.
        u_if.rx_serial = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        u_if.rx_serial = 1'b1;
        busy_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (u_if.rx_busy) busy_cnt++;
        end
        check_range("glitch_busy_cycles", busy_cnt, 7, 9);
        @(posedge clk);
        #1;
        idle(10);

        // Framing error after a good byte; rx_data must keep the good byte.
        send_frame(8'h11, 1'b1);
        send_frame(8'h3C, 1'b0);
        idle(20);
        drain("drain_frame_err");
        check("data_after_frame_err", {24'd0, u_if.rx_data}, 32'h11);

        // Reset during data bit 4 aborts the frame without a pulse.
        hold_bit(1'b0);
        b = 8'hE7;
        for (int i = 0; i < 4; i++) hold_bit(b[i]);
        u_if.rx_serial = b[4];
        repeat (HALF) @(posedge clk);
        #1;
        rst_ = 1'b0;
        @(negedge clk);
        check("midrst_rx_data", {24'd0, u_if.rx_data}, 32'd0);
        check("midrst_rx_busy", {31'd0, u_if.rx_busy}, 32'd0);
        check("midrst_pulses", {30'd0, u_if.rx_valid, u_if.rx_frame_err}, 32'd0);
        last_good = 8'h00;
        u_if.rx_serial = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_ = 1'b1;
        idle(DIV * 12);
        send_frame(8'h5A, 1'b1);
        idle(20);
        drain("drain_after_reset");

        // Loopback-style transmitter bytes.
        send_frame(8'hC3, 1'b1);
        send_frame(8'h00, 1'b1);
        idle(5);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        idle(20);

        // Randomized bytes, stop bits and gaps; errors get a recovery gap.
        for (int k = 0; k < 40; k++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            gap  = stop ? int'($urandom_range(0, 3)) : int'($urandom_range(8, 15));
            send_frame(b, stop);
            idle(gap);
        end
        idle(20);
        drain("drain_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
